load_store_unit: RTL and testbench

- Initiator side of the core's data-memory interface: accepts load/store requests from the execute/memory stage and drives the word-addressed data memory's mem_read/mem_write/address/write_data.
- Returns sign/zero-extended load data.
- The memory has no byte enables, so SB/SH are performed as read-modify-write.
- Sits between the pipeline MEM stage and the data memory; the only master of that memory.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/load_store_unit_if.sv | 26 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store funct3
// encodings, the FSM state type and small address-decode helpers.
package lsu_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    // Byte lane after forcing the access to its natural alignment.
    function automatic logic [1:0] natural_lane(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return {lo[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return lo;
        endcase
    endfunction

    // True when the low address bits break the access's natural alignment.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel between the pipeline MEM stage (master) and the
// load/store unit (slave). Both directions use a valid/ready handshake.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Load path: pick byte/half/word from a memory word and sign/zero-extend.
// Store path: merge the low byte/half of the store data into the old word
// (the memory has no byte enables, so sub-word stores are read-modify-write).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [1:0]        i_lane,
    input  logic [2:0]        i_funct3,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    // Extract the addressed lane and extend it to a full word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_byte      = i_word[{i_lane, 3'b000} +: 8];
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            F3_W:    o_load_data = i_word;
            default: o_load_data = '0;
        endcase
    end

    // Overlay the store byte/half onto the previously read word.
    always_comb begin
        o_store_word = i_word;
        case (i_funct3)
            F3_B:    o_store_word[{i_lane, 3'b000} +: 8]  = i_wdata[7:0];
            F3_H:    o_store_word[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            F3_W:    o_store_word = i_wdata;
            default: o_store_word = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator on the word-addressed data memory. Accepts one
// load/store request at a time, performs SB/SH as read-modify-write, and
// returns sign/zero-extended load data with an error flag.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors; otherwise the low address bits are forced to natural
// alignment and the access proceeds.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                clock,
    input  logic                rst,
    load_store_unit_if.slave    bus,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   address,
    output logic [WORD_W-1:0]   write_data,
    input  logic [WORD_W-1:0]   read_data
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic              r_error;
    logic [ADDR_W-1:0] r_address;
    logic [WORD_W-1:0] r_write_data;

    logic [ADDR_W-1:0] w_word_idx;
    logic              w_oob;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_err;
    logic [1:0]        w_lane;
    logic              w_accept;
    logic [WORD_W-1:0] w_load_data;
    logic [WORD_W-1:0] w_store_word;
    logic              w_req_ready;
    logic              w_resp_valid;
    logic              w_mem_read;
    logic              w_mem_write;

    // Request decode, evaluated while IDLE on the incoming fields.
    assign w_word_idx = {2'b00, bus.req_addr[ADDR_W-1:2]};
    assign w_oob      = w_word_idx >= ADDR_W'(MEM_WORDS);
    assign w_illegal  = !f3_legal(bus.req_we, bus.req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign w_lane     = bus.req_addr[1:0];
`else
    assign w_misalign = 1'b0;
    assign w_lane     = natural_lane(bus.req_funct3, bus.req_addr[1:0]);
`endif

    assign w_err    = w_illegal || w_oob || w_misalign;
    assign w_accept = (r_state == IDLE) && bus.req_valid;

    lsu_align u_align (
        .i_word       (read_data),
        .i_wdata      (r_wdata),
        .i_lane       (r_lane),
        .i_funct3     (r_funct3),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state selection and per-state strobes.
    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_err)                                  w_next = RESP;
                    else if (bus.req_we && bus.req_funct3 == F3_W) w_next = WR_REQ;
                    else                                        w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                w_mem_read = 1'b1;
                w_next     = RD_WAIT;
            end
            RD_WAIT: begin
                w_next = r_we ? WR_REQ : RESP;
            end
            WR_REQ: begin
                w_mem_write = 1'b1;
                w_next      = RESP;
            end
            RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch at acceptance, then read-data capture in RD_WAIT.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_lane       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
            r_address    <= '0;
            r_write_data <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_lane   <= w_lane;
                r_wdata  <= bus.req_wdata;
                r_rdata  <= '0;
                r_error  <= w_err;
                // Errored requests never touch memory, so the bus keeps its last value.
                if (!w_err) begin
                    r_address <= w_word_idx;
                    if (bus.req_we && bus.req_funct3 == F3_W) r_write_data <= bus.req_wdata;
                end
            end else if (r_state == RD_WAIT) begin
                // read_data is only meaningful here; the memory drives 0 otherwise.
                if (r_we) r_write_data <= w_store_word;
                else      r_rdata      <= w_load_data;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_error;
    assign mem_read       = w_mem_read;
    assign mem_write      = w_mem_write;
    assign address        = r_address;
    assign write_data     = r_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data memory and a
// scoreboard of expected responses (data, error, latency, strobe counts).
module tb_load_store_unit;

    localparam int MEM_WORDS = 256;
    localparam int ADDR_W    = 32;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rds;
        int          wrs;
    } exp_t;

    logic              clock = 1'b0;
    logic              rst   = 1'b1;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;

    logic [31:0] mem [0:MEM_WORDS-1];
    exp_t        sb[$];

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_rd   = 0;
    int          n_wr   = 0;
    int          n_both = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .rst        (rst),
        .bus        (bus),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clock = ~clock;

    // Data memory: registered read, drives 0 when not reading.
    always @(posedge clock) begin
        read_data <= mem_read ? mem[address[7:0]] : 32'd0;
        if (mem_write) mem[address[7:0]] <= write_data;
    end

    // Strobe monitor sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_read)  begin n_rd++; last_rd_addr = address; end
        if (mem_write) begin n_wr++; last_wr_addr = address; last_wr_data = write_data; end
        if (mem_read && mem_write) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its response, compare against the scoreboard.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] e_rdata, input logic e_err,
                           input int e_lat, input int e_rds, input int e_wrs,
                           input int stall);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          rd0;
        int          wr0;
        logic [31:0] held;
        e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.rds = e_rds; e.wrs = e_wrs;
        sb.push_back(e);
        @(negedge clock);
        n_rd = 0;
        n_wr = 0;
        check({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (stall == 0);
        @(posedge clock);
        lat = 0;
        do begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            lat++;
        end while (!bus.resp_valid && lat < 20);
        got = sb.pop_front();
        check({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(got.lat));
        check({tag, " rdata"}, bus.resp_rdata, got.rdata);
        check({tag, " error"}, {31'd0, bus.resp_error}, {31'd0, got.err});
        if (stall > 0) begin
            held = bus.resp_rdata;
            rd0  = n_rd;
            wr0  = n_wr;
            for (int i = 0; i < stall; i++) begin
                @(negedge clock);
                check({tag, " stall valid"}, {31'd0, bus.resp_valid}, 32'd1);
                check({tag, " stall rdata"}, bus.resp_rdata, held);
                check({tag, " stall req_ready"}, {31'd0, bus.req_ready}, 32'd0);
            end
            check({tag, " stall reads"}, 32'(n_rd), 32'(rd0));
            check({tag, " stall writes"}, 32'(n_wr), 32'(wr0));
            bus.resp_ready = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        check({tag, " done valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, " reads"}, 32'(n_rd), 32'(got.rds));
        check({tag, " writes"}, 32'(n_wr), 32'(got.wrs));
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;
        mem[10] = 32'h0000_0010;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst resp_error", {31'd0, bus.resp_error}, 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst mem_read",   {31'd0, mem_read},  32'd0);
        check("rst mem_write",  {31'd0, mem_write}, 32'd0);
        check("rst address",    address,    32'd0);
        check("rst write_data", write_data, 32'd0);
        rst = 1'b0;

        // Word load from the preloaded location.
        run_req("LW 0x28", 1'b0, 3'b010, 32'h28, 32'h0, 32'h0000_0010, 1'b0, 3, 1, 0, 0);
        check("LW 0x28 rd addr", last_rd_addr, 32'd10);

        // Word store then sub-word loads.
        run_req("SW 0x28", 1'b1, 3'b010, 32'h28, 32'h8081_82F3, 32'h0, 1'b0, 2, 0, 1, 0);
        check("SW wr addr", last_wr_addr, 32'd10);
        check("SW wr data", last_wr_data, 32'h8081_82F3);
        run_req("LB 0x28",  1'b0, 3'b000, 32'h28, 32'h0, 32'hFFFF_FFF3, 1'b0, 3, 1, 0, 0);
        run_req("LBU 0x29", 1'b0, 3'b100, 32'h29, 32'h0, 32'h0000_0082, 1'b0, 3, 1, 0, 0);
        run_req("LH 0x2A",  1'b0, 3'b001, 32'h2A, 32'h0, 32'hFFFF_8081, 1'b0, 3, 1, 0, 0);
        run_req("LHU 0x2A", 1'b0, 3'b101, 32'h2A, 32'h0, 32'h0000_8081, 1'b0, 3, 1, 0, 0);

        // Byte store as read-modify-write.
        run_req("SB 0x2B", 1'b1, 3'b000, 32'h2B, 32'h0000_00AA, 32'h0, 1'b0, 4, 1, 1, 0);
        check("SB wr addr", last_wr_addr, 32'd10);
        check("SB wr data", last_wr_data, 32'hAA81_82F3);

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        run_req("LW 0x2A", 1'b0, 3'b010, 32'h2A, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
`else
        run_req("LW 0x2A", 1'b0, 3'b010, 32'h2A, 32'h0, 32'hAA81_82F3, 1'b0, 3, 1, 0, 0);
`endif

        // Half store into the upper half, then readback.
        run_req("SH 0x2A", 1'b1, 3'b001, 32'h2A, 32'hFFFF_1234, 32'h0, 1'b0, 4, 1, 1, 0);
        check("SH wr data", last_wr_data, 32'h1234_82F3);
        run_req("LB 0x2B", 1'b0, 3'b000, 32'h2B, 32'h0, 32'h0000_0012, 1'b0, 3, 1, 0, 0);

        // Response back-pressure.
        run_req("LW stall", 1'b0, 3'b010, 32'h28, 32'h0, 32'h1234_82F3, 1'b0, 3, 1, 0, 5);

        // Error cases.
        run_req("LW oob",    1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        run_req("LD f3 011", 1'b0, 3'b011, 32'h28,  32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
        run_req("ST f3 100", 1'b1, 3'b100, 32'h28,  32'h5, 32'h0, 1'b1, 1, 0, 0, 0);
        run_req("LW last",   1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0, 1'b0, 3, 1, 0, 0);

        // Reset while waiting for read data.
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h28;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rstmid req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("rstmid resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rstmid mem_read",   {31'd0, mem_read},  32'd0);
        check("rstmid mem_write",  {31'd0, mem_write}, 32'd0);
        rst = 1'b0;
        run_req("LW after rst", 1'b0, 3'b010, 32'h28, 32'h0, 32'h1234_82F3, 1'b0, 3, 1, 0, 0);

        check("strobe overlap", 32'(n_both), 32'd0);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
